// File: rtl/ex_sorter_sorted_serializer.sv
// ex_sorter_sorted_serializer: buffers sorted 4-tuples from the sorter and streams their elements out in ascending order
//   clk       : clock
//   reset     : synchronous, active-low reset
//   in_val    : a sorted tuple is present on in0..in3 (sorter's out_val)
//   in0..in3  : sorted elements, in0 smallest
//   out_val   : out_msg is valid
//   out_rdy   : consumer accepts out_msg this cycle
//   out_msg   : current element
//   out_idx   : position of out_msg within its tuple
//   out_last  : out_msg is the final element of its tuple
//   count     : tuples held, including a partly drained one
//   overflow  : sticky, a tuple was dropped because the buffer was full
module ex_sorter_sorted_serializer #(
    parameter int p_nbits    = 8,
    parameter int p_nentries = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_val,
    input  logic [p_nbits-1:0]                  in0,
    input  logic [p_nbits-1:0]                  in1,
    input  logic [p_nbits-1:0]                  in2,
    input  logic [p_nbits-1:0]                  in3,
    output logic                                out_val,
    input  logic                                out_rdy,
    output logic [p_nbits-1:0]                  out_msg,
    output logic [1:0]                          out_idx,
    output logic                                out_last,
    output logic [$clog2(p_nentries+1)-1:0]     count,
    output logic                                overflow
);
    localparam int CW = $clog2(p_nentries + 1);
    localparam int PW = $clog2(p_nentries);
    localparam logic [CW-1:0] FULL = CW'(p_nentries);
    logic [p_nbits-1:0] slot_q [p_nentries][4];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          fire, pop, full, enq;
    // A full buffer still accepts a tuple in the cycle its head tuple pops.
    // The 2-bit idx wraps 3->0 on its own, so a pop needs no special case there.
    always_comb begin
        fire     = (count_q != '0) & out_rdy;
        pop      = fire & (idx_q == 2'd3);
        full     = count_q == FULL;
        enq      = in_val & (~full | pop);
        idx_d    = fire ? idx_q + 2'd1 : idx_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = enq ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d  = count_q + CW'(enq) - CW'(pop);
        ovf_d    = ovf_q | (in_val & full & ~pop);
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            idx_q    <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end
    // Payload storage needs no reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (reset && enq) begin
            slot_q[wr_ptr_q][0] <= in0;
            slot_q[wr_ptr_q][1] <= in1;
            slot_q[wr_ptr_q][2] <= in2;
            slot_q[wr_ptr_q][3] <= in3;
        end
    end
    assign out_val  = count_q != '0;
    assign out_msg  = out_val ? slot_q[rd_ptr_q][idx_q] : '0;
    assign out_idx  = out_val ? idx_q : 2'd0;
    assign out_last = out_val & (idx_q == 2'd3);
    assign count    = count_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_ex_sorter_sorted_serializer.sv
// tb_ex_sorter_sorted_serializer: table-driven, directed and randomized checks of the sorted serializer
module tb_ex_sorter_sorted_serializer;
    localparam int NB = 8;
    localparam int NE = 2;
    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_val = 1'b0;
    logic          out_rdy = 1'b0;
    logic [NB-1:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
    logic          out_val, out_last, overflow;
    logic [NB-1:0] out_msg;
    logic [1:0]    out_idx;
    logic [1:0]    count;
    int            nvec = 0;
    int            nerr = 0;
    // Reference model: a queue of whole tuples plus the element position in the head tuple.
    logic [31:0]   mq[$];
    int            midx = 0;
    bit            movf = 1'b0;
    typedef struct {
        bit          r;
        bit          v;
        logic [31:0] t;
        bit          rdy;
        bit          ev;
        logic [7:0]  em;
        logic [1:0]  ei;
        bit          el;
        logic [1:0]  ec;
        bit          eo;
    } vec_t;
    vec_t tbl[$];
    always #5 clk = ~clk;
    ex_sorter_sorted_serializer #(.p_nbits(NB), .p_nentries(NE)) dut (
        .clk(clk), .reset(reset), .in_val(in_val),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg),
        .out_idx(out_idx), .out_last(out_last), .count(count), .overflow(overflow)
    );
    function automatic logic [31:0] tup(int a, int b, int c, int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction
    function automatic logic [7:0] el_of(logic [31:0] t, int k);
        return t[8*k +: 8];
    endfunction
    function automatic vec_t mk(bit r, bit v, logic [31:0] t, bit rdy, bit ev, int em, int ei, bit el, int ec, bit eo);
        vec_t x;
        x.r = r; x.v = v; x.t = t; x.rdy = rdy;
        x.ev = ev; x.em = 8'(em); x.ei = 2'(ei); x.el = el; x.ec = 2'(ec); x.eo = eo;
        return x;
    endfunction
    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic drive(bit r, bit v, logic [31:0] t, bit rdy);
        reset = r;
        in_val = v;
        {in3, in2, in1, in0} = t;
        out_rdy = rdy;
    endtask
    // Applies the spec rules at a clock edge: pop a finished tuple first, then accept if room remains.
    task automatic model_edge();
        logic [31:0] h;
        if (!reset) begin
            mq.delete();
            midx = 0;
            movf = 1'b0;
        end else begin
            if (mq.size() != 0 && out_rdy) begin
                if (midx == 3) begin
                    h = mq.pop_front();
                    midx = 0;
                end else midx++;
            end
            if (in_val) begin
                if (mq.size() < NE) mq.push_back({in3, in2, in1, in0});
                else movf = 1'b1;
            end
        end
    endtask
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask
    task automatic chk_model(string tag);
        logic [31:0] h;
        bit mv;
        mv = mq.size() != 0;
        h = mv ? mq[0] : 32'd0;
        chk({tag, "_val"}, 32'(out_val), 32'(mv));
        chk({tag, "_msg"}, 32'(out_msg), mv ? 32'(el_of(h, midx)) : 32'd0);
        chk({tag, "_idx"}, 32'(out_idx), mv ? 32'(midx) : 32'd0);
        chk({tag, "_last"}, 32'(out_last), 32'(mv && midx == 3));
        chk({tag, "_cnt"}, 32'(count), 32'(mq.size()));
        chk({tag, "_ovf"}, 32'(overflow), 32'(movf));
    endtask
    initial begin
        logic [31:0] z, tt[5], t;
        logic [7:0]  eq[$];
        z = 32'd0;
        tbl.push_back(mk(1, 1, tup(1, 3, 5, 9), 1, 1, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, z, 1, 1, 3, 1, 0, 1, 0));
        tbl.push_back(mk(1, 0, z, 1, 1, 5, 2, 0, 1, 0));
        tbl.push_back(mk(1, 0, z, 1, 1, 9, 3, 1, 1, 0));
        tbl.push_back(mk(1, 0, z, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, tup(2, 2, 7, 8), 0, 1, 2, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, z, 0, 1, 2, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, z, 0, 1, 2, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, z, 1, 1, 2, 1, 0, 1, 0));
        tbl.push_back(mk(1, 0, z, 1, 1, 7, 2, 0, 1, 0));
        tbl.push_back(mk(1, 0, z, 1, 1, 8, 3, 1, 1, 0));
        tbl.push_back(mk(1, 0, z, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, tup(10, 11, 12, 13), 0, 1, 10, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, tup(20, 21, 22, 23), 0, 1, 10, 0, 0, 2, 0));
        tbl.push_back(mk(1, 1, tup(30, 31, 32, 33), 0, 1, 10, 0, 0, 2, 1));
        tbl.push_back(mk(1, 0, z, 1, 1, 11, 1, 0, 2, 1));
        tbl.push_back(mk(1, 0, z, 1, 1, 12, 2, 0, 2, 1));
        tbl.push_back(mk(1, 0, z, 1, 1, 13, 3, 1, 2, 1));
        tbl.push_back(mk(1, 0, z, 1, 1, 20, 0, 0, 1, 1));
        tbl.push_back(mk(1, 0, z, 1, 1, 21, 1, 0, 1, 1));
        tbl.push_back(mk(1, 0, z, 1, 1, 22, 2, 0, 1, 1));
        tbl.push_back(mk(1, 0, z, 1, 1, 23, 3, 1, 1, 1));
        tbl.push_back(mk(1, 0, z, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, tup(99, 99, 99, 99), 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, tup(40, 41, 42, 43), 0, 1, 40, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, tup(50, 51, 52, 53), 0, 1, 40, 0, 0, 2, 0));
        tbl.push_back(mk(1, 0, z, 1, 1, 41, 1, 0, 2, 0));
        tbl.push_back(mk(1, 0, z, 1, 1, 42, 2, 0, 2, 0));
        tbl.push_back(mk(1, 0, z, 1, 1, 43, 3, 1, 2, 0));
        tbl.push_back(mk(1, 1, tup(60, 61, 62, 63), 1, 1, 50, 0, 0, 2, 0));
        tbl.push_back(mk(1, 0, z, 1, 1, 51, 1, 0, 2, 0));
        tbl.push_back(mk(1, 0, z, 1, 1, 52, 2, 0, 2, 0));
        tbl.push_back(mk(1, 0, z, 1, 1, 53, 3, 1, 2, 0));
        tbl.push_back(mk(1, 0, z, 1, 1, 60, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, z, 1, 1, 61, 1, 0, 1, 0));
        tbl.push_back(mk(1, 0, z, 1, 1, 62, 2, 0, 1, 0));
        tbl.push_back(mk(1, 0, z, 1, 1, 63, 3, 1, 1, 0));
        tbl.push_back(mk(1, 0, z, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, tup(1, 1, 2, 2), 1, 1, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, tup(3, 4, 5, 6), 1, 1, 1, 1, 0, 2, 0));
        tbl.push_back(mk(1, 0, z, 1, 1, 2, 2, 0, 2, 0));
        tbl.push_back(mk(1, 0, z, 1, 1, 2, 3, 1, 2, 0));
        tbl.push_back(mk(1, 0, z, 1, 1, 3, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, z, 1, 1, 4, 1, 0, 1, 0));
        tbl.push_back(mk(1, 0, z, 1, 1, 5, 2, 0, 1, 0));
        tbl.push_back(mk(1, 0, z, 1, 1, 6, 3, 1, 1, 0));
        tbl.push_back(mk(1, 0, z, 1, 0, 0, 0, 0, 0, 0));
        drive(0, 0, z, 0);
        repeat (2) step();
        chk("rst_val", 32'(out_val), 0);
        chk("rst_msg", 32'(out_msg), 0);
        chk("rst_idx", 32'(out_idx), 0);
        chk("rst_last", 32'(out_last), 0);
        chk("rst_cnt", 32'(count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].t, tbl[i].rdy);
            step();
            chk($sformatf("row%0d_val", i), 32'(out_val), 32'(tbl[i].ev));
            chk($sformatf("row%0d_msg", i), 32'(out_msg), 32'(tbl[i].em));
            chk($sformatf("row%0d_idx", i), 32'(out_idx), 32'(tbl[i].ei));
            chk($sformatf("row%0d_last", i), 32'(out_last), 32'(tbl[i].el));
            chk($sformatf("row%0d_cnt", i), 32'(count), 32'(tbl[i].ec));
            chk($sformatf("row%0d_ovf", i), 32'(overflow), 32'(tbl[i].eo));
        end
        // Reset while a tuple is half drained.
        drive(1, 1, tup(4, 5, 6, 7), 1);
        step();
        drive(1, 0, z, 1);
        repeat (2) step();
        chk("mid_msg", 32'(out_msg), 6);
        chk("mid_idx", 32'(out_idx), 2);
        drive(0, 0, z, 1);
        step();
        chk("mid_rst_val", 32'(out_val), 0);
        chk("mid_rst_cnt", 32'(count), 0);
        chk("mid_rst_idx", 32'(out_idx), 0);
        drive(1, 1, tup(0, 0, 1, 1), 1);
        step();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("post_msg%0d", k), 32'(out_msg), 32'(el_of(tup(0, 0, 1, 1), k)));
            chk($sformatf("post_idx%0d", k), 32'(out_idx), 32'(k));
            chk($sformatf("post_last%0d", k), 32'(out_last), 32'(k == 3));
            drive(1, 0, z, 1);
            step();
        end
        chk("post_val", 32'(out_val), 0);
        chk("post_cnt", 32'(count), 0);
        // Five tuples back to back at one per four cycles wrap both pointers.
        for (int j = 0; j < 5; j++) tt[j] = $urandom;
        drive(1, 1, tt[0], 1);
        step();
        for (int j = 0; j < 5; j++) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("wrap%0d_msg%0d", j, k), 32'(out_msg), 32'(el_of(tt[j], k)));
                chk($sformatf("wrap%0d_idx%0d", j, k), 32'(out_idx), 32'(k));
                chk($sformatf("wrap%0d_cnt%0d", j, k), 32'(count), 1);
                drive(1, k == 3 && j < 4, j < 4 ? tt[j+1] : z, 1);
                step();
            end
        end
        chk("wrap_val", 32'(out_val), 0);
        chk("wrap_ovf", 32'(overflow), 0);
        // Random traffic against the queue model.
        for (int c = 0; c < 3000; c++) begin
            chk_model($sformatf("rnd%0d", c));
            eq.delete();
            for (int k = 0; k < 4; k++) eq.push_back(8'($urandom));
            eq.sort();
            t = {eq[3], eq[2], eq[1], eq[0]};
            drive($urandom_range(149) != 0, $urandom_range(99) < 35, t, $urandom_range(99) < 75);
            step();
        end
        chk_model("rnd_end");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
